// File: rtl/ndp_ahb_pkg.sv
// Shared AHB-Lite encodings and result-writer FSM state codes.
// The slave-side scratch-pad decoder imports the same transfer constants.
package ndp_ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;
  localparam logic [2:0] HBURST_INCR   = 3'b001;
  localparam logic [2:0] HSIZE_WORD    = 3'b010;
  localparam logic [3:0] HPROT_DATA    = 4'b0011;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_XFER  = 3'd1;
  localparam state_t ST_DRAIN = 3'd2;
  localparam state_t ST_ERR   = 3'd3;
  localparam state_t ST_FIN   = 3'd4;

endpackage

// File: rtl/result_word_mux.sv
// Combinational selector of one 32-bit word out of the wide result vector.
module result_word_mux #(
  parameter int RESULT_WIDTH = 16384,
  parameter int IDX_W        = 10
) (
  input  logic [RESULT_WIDTH-1:0] data,
  input  logic [IDX_W-1:0]        idx,
  output logic [31:0]             word
);

  // Out-of-range indices yield zero; the parent only samples in-range words.
  always_comb begin
    word = '0;
    for (int k = 0; k < RESULT_WIDTH / 32; k++) begin
      if (idx == IDX_W'(k)) word = data[32*k +: 32];
    end
  end

endmodule

// File: rtl/ndp_result_writer.sv
// AHB-Lite master that drains the NDP result vector into DRAM as an INCR
// burst of 32-bit words, with wait-state and two-cycle ERROR handling.
module ndp_result_writer
  import ndp_ahb_pkg::*;
#(
  parameter int RESULT_WIDTH = 16384,
  parameter int ADDR_WIDTH   = 32
) (
  input  logic                    HCLK,
  input  logic                    HRESETn,
  input  logic                    start,
  input  logic [ADDR_WIDTH-1:0]   base_addr,
  input  logic [RESULT_WIDTH-1:0] result,
  output logic                    busy,
  output logic                    done,
  output logic                    error,
  output logic [ADDR_WIDTH-1:0]   HADDR,
  output logic [1:0]              HTRANS,
  output logic                    HWRITE,
  output logic [2:0]              HSIZE,
  output logic [2:0]              HBURST,
  output logic [3:0]              HPROT,
  output logic                    HMASTLOCK,
  output logic [31:0]             HWDATA,
  input  logic                    HREADY,
  input  logic                    HRESP
);

  localparam int N     = RESULT_WIDTH / 32;
  localparam int IDX_W = $clog2(N) + 1;

  state_t                state;
  logic [ADDR_WIDTH-1:0] base;
  logic [IDX_W-1:0]      addr_idx;
  logic [IDX_W-1:0]      data_idx;
  logic [31:0]           mux_word;
  logic                  data_pending;
  logic                  last_addr;
  logic                  err_first;

  result_word_mux #(
    .RESULT_WIDTH(RESULT_WIDTH),
    .IDX_W       (IDX_W)
  ) u_word_mux (
    .data(result),
    .idx (addr_idx),
    .word(mux_word)
  );

  assign HADDR        = base + (ADDR_WIDTH'(addr_idx) << 2);
  assign data_pending = (data_idx != addr_idx);
  assign last_addr    = (addr_idx == IDX_W'(N - 1));
  assign err_first    = HRESP && !HREADY && data_pending &&
                        ((state == ST_XFER) || (state == ST_DRAIN));

  assign busy      = (state == ST_XFER) || (state == ST_DRAIN) || (state == ST_ERR);
  assign done      = (state == ST_FIN);
  assign HWRITE    = busy;
  assign HSIZE     = HSIZE_WORD;
  assign HBURST    = HBURST_INCR;
  assign HPROT     = HPROT_DATA;
  assign HMASTLOCK = 1'b0;

  // A burst restarts with NONSEQ at the first word and at every 1 KB crossing.
  always_comb begin
    HTRANS = HTRANS_IDLE;
    if (state == ST_XFER) begin
      if ((addr_idx == '0) || (HADDR[9:0] == 10'd0)) HTRANS = HTRANS_NONSEQ;
      else                                            HTRANS = HTRANS_SEQ;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state    <= ST_IDLE;
      base     <= '0;
      addr_idx <= '0;
      data_idx <= '0;
      HWDATA   <= '0;
      error    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            base     <= base_addr & ~ADDR_WIDTH'(3);
            addr_idx <= '0;
            data_idx <= '0;
            error    <= 1'b0;
            state    <= ST_XFER;
          end
        end
        // One HREADY completes the pending data phase and accepts the next address.
        ST_XFER: begin
          if (err_first) begin
            error <= 1'b1;
            state <= ST_ERR;
          end else if (HREADY) begin
            if (data_pending) data_idx <= data_idx + 1'b1;
            addr_idx <= addr_idx + 1'b1;
            HWDATA   <= mux_word;
            if (last_addr) state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (err_first) begin
            error <= 1'b1;
            state <= ST_ERR;
          end else if (HREADY) begin
            data_idx <= data_idx + 1'b1;
            state    <= ST_FIN;
          end
        end
        ST_ERR: begin
          if (HREADY) state <= ST_FIN;
        end
        ST_FIN:  state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ndp_result_writer.sv
// Scoreboard bench for ndp_result_writer with a 4-word result vector:
// directed bursts push expected phases, a negedge monitor pops and compares.
module tb_ndp_result_writer;
  import ndp_ahb_pkg::*;

  localparam int RW = 128;
  localparam int AW = 32;

  logic          HCLK = 1'b0;
  logic          HRESETn;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [RW-1:0] result;
  logic          busy, done, error;
  logic [AW-1:0] HADDR;
  logic [1:0]    HTRANS;
  logic          HWRITE;
  logic [2:0]    HSIZE, HBURST;
  logic [3:0]    HPROT;
  logic          HMASTLOCK;
  logic [31:0]   HWDATA;
  logic          HREADY;
  logic          HRESP;

  ndp_result_writer #(.RESULT_WIDTH(RW), .ADDR_WIDTH(AW)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .start(start), .base_addr(base_addr),
    .result(result), .busy(busy), .done(done), .error(error),
    .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE),
    .HBURST(HBURST), .HPROT(HPROT), .HMASTLOCK(HMASTLOCK), .HWDATA(HWDATA),
    .HREADY(HREADY), .HRESP(HRESP)
  );

  always #5 HCLK = ~HCLK;

  typedef struct { logic [31:0] addr; logic [1:0] trans; } addr_exp_t;
  typedef struct { int cyc; bit err; int left; } done_exp_t;

  addr_exp_t   aq[$];
  logic [31:0] dq[$];
  done_exp_t   dnq[$];
  int          dp = 0;
  int          cyc = 0;
  bit          done_seen = 0;
  int          vectors = 0;
  int          miscompares = 0;

  localparam logic [127:0] RES_A = {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
  localparam logic [127:0] RES_B = {32'hDEAD_BEEF, 32'h0BAD_F00D, 32'hCAFE_0001, 32'h1234_5678};

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic pushAddr(input logic [31:0] a, input logic [1:0] t);
    addr_exp_t e;
    e.addr = a; e.trans = t;
    aq.push_back(e);
  endtask

  task automatic pushWords(input logic [127:0] res, input int n);
    for (int k = 0; k < n; k++) dq.push_back(res[32*k +: 32]);
  endtask

  task automatic pushDone(input int c, input bit e, input int left);
    done_exp_t d;
    d.cyc = c; d.err = e; d.left = left;
    dnq.push_back(d);
  endtask

  // Drives one burst: wait cycles wlo..whi, ERROR starting at ecyc, a second
  // start in cycle sc, and a reset pulse in cycle rc (-1 disables each).
  task automatic applyStimulus(input logic [31:0] base, input logic [127:0] res,
                               input int wlo, input int whi, input int ecyc,
                               input int sc, input logic [31:0] sbase,
                               input int rc, input bit exp_err);
    bit aborted = 0;
    done_seen = 0;
    @(negedge HCLK);
    base_addr = base; result = res; start = 1'b1; HREADY = 1'b1; HRESP = 1'b0;
    @(posedge HCLK); #1;
    start = 1'b0;
    cyc = 1;
    while (!done_seen && !aborted && cyc < 40) begin
      HREADY = !((cyc >= wlo && cyc <= whi) || cyc == ecyc);
      HRESP  = (cyc == ecyc) || (cyc == ecyc + 1);
      if (cyc == sc) begin start = 1'b1; base_addr = sbase; end
      else start = 1'b0;
      if (cyc == 1) checkOutput("error_cleared", {31'd0, error}, 32'd0);
      if (cyc == rc) begin
        HRESETn = 1'b0;
        #1;
        checkOutput("rst_htrans", {30'd0, HTRANS}, {30'd0, HTRANS_IDLE});
        checkOutput("rst_busy", {31'd0, busy}, 32'd0);
        checkOutput("rst_done", {31'd0, done}, 32'd0);
        checkOutput("rst_haddr", HADDR, 32'd0);
        @(posedge HCLK); #1;
        HRESETn = 1'b1;
        aborted = 1;
      end else begin
        @(posedge HCLK); #1;
        cyc++;
      end
    end
    start = 1'b0; HREADY = 1'b1; HRESP = 1'b0;
    if (!done_seen && !aborted) checkOutput("done_timeout", 32'd0, 32'd1);
    repeat (3) @(posedge HCLK);
    #1;
    checkOutput("error_sticky", {31'd0, error}, {31'd0, exp_err});
  endtask

  // Monitor: the data phase is checked before the address phase so that a
  // completing data phase and a newly accepted address share one cycle.
  always @(negedge HCLK) begin
    if (!HRESETn) begin
      aq.delete(); dq.delete(); dnq.delete();
      dp = 0;
    end else begin
      if (dp > 0) begin
        checkOutput("busy_data", {31'd0, busy}, 32'd1);
        if (dq.size() > 0) checkOutput("hwdata", HWDATA, dq[0]);
        if (HREADY) begin
          if (dq.size() > 0) void'(dq.pop_front());
          dp--;
        end
      end
      if (HTRANS != HTRANS_IDLE) begin
        if (aq.size() == 0) begin
          checkOutput("unexpected_addr", {30'd0, HTRANS}, {30'd0, HTRANS_IDLE});
        end else begin
          checkOutput("haddr", HADDR, aq[0].addr);
          checkOutput("htrans", {30'd0, HTRANS}, {30'd0, aq[0].trans});
          checkOutput("hwrite", {31'd0, HWRITE}, 32'd1);
          checkOutput("hsize_hburst", {26'd0, HSIZE, HBURST}, {26'd0, 3'b010, 3'b001});
          checkOutput("hprot_lock", {27'd0, HPROT, HMASTLOCK}, {27'd0, 4'b0011, 1'b0});
          if (HREADY) begin
            void'(aq.pop_front());
            dp++;
          end
        end
      end
      if (done) begin
        done_seen = 1;
        if (dnq.size() == 0) begin
          checkOutput("unexpected_done", {31'd0, done}, 32'd0);
        end else begin
          checkOutput("done_cycle", cyc, dnq[0].cyc);
          checkOutput("done_error", {31'd0, error}, {31'd0, dnq[0].err});
          checkOutput("done_busy", {31'd0, busy}, 32'd0);
          checkOutput("addr_left", aq.size(), dnq[0].left);
          checkOutput("data_left", dq.size(), 32'd0);
          void'(dnq.pop_front());
        end
        aq.delete();
      end
    end
  end

  initial begin
    HRESETn = 1'b0; start = 1'b0; base_addr = '0; result = '0;
    HREADY = 1'b1; HRESP = 1'b0;
    #12;
    checkOutput("reset_htrans", {30'd0, HTRANS}, 32'd0);
    checkOutput("reset_haddr", HADDR, 32'd0);
    checkOutput("reset_hwdata", HWDATA, 32'd0);
    checkOutput("reset_flags", {28'd0, HWRITE, busy, done, error}, 32'd0);
    @(negedge HCLK);
    HRESETn = 1'b1;

    $display("[TB] zero-wait burst");
    pushAddr(32'h1000_0000, HTRANS_NONSEQ); pushAddr(32'h1000_0004, HTRANS_SEQ);
    pushAddr(32'h1000_0008, HTRANS_SEQ);    pushAddr(32'h1000_000C, HTRANS_SEQ);
    pushWords(RES_A, 4); pushDone(6, 0, 0);
    applyStimulus(32'h1000_0000, RES_A, -1, -1, -1, -1, 32'h0, -1, 0);

    $display("[TB] wait states on second data phase");
    pushAddr(32'h1000_0000, HTRANS_NONSEQ); pushAddr(32'h1000_0004, HTRANS_SEQ);
    pushAddr(32'h1000_0008, HTRANS_SEQ);    pushAddr(32'h1000_000C, HTRANS_SEQ);
    pushWords(RES_A, 4); pushDone(8, 0, 0);
    applyStimulus(32'h1000_0000, RES_A, 3, 4, -1, -1, 32'h0, -1, 0);

    $display("[TB] 1 KB boundary restart");
    pushAddr(32'h0000_03F8, HTRANS_NONSEQ); pushAddr(32'h0000_03FC, HTRANS_SEQ);
    pushAddr(32'h0000_0400, HTRANS_NONSEQ); pushAddr(32'h0000_0404, HTRANS_SEQ);
    pushWords(RES_B, 4); pushDone(6, 0, 0);
    applyStimulus(32'h0000_03F8, RES_B, -1, -1, -1, -1, 32'h0, -1, 0);

    $display("[TB] ERROR on word 1");
    pushAddr(32'h1000_0000, HTRANS_NONSEQ); pushAddr(32'h1000_0004, HTRANS_SEQ);
    pushAddr(32'h1000_0008, HTRANS_SEQ);
    pushWords(RES_A, 2); pushDone(5, 1, 1);
    applyStimulus(32'h1000_0000, RES_A, -1, -1, 3, -1, 32'h0, -1, 1);

    $display("[TB] start while busy, error cleared");
    pushAddr(32'h1000_0000, HTRANS_NONSEQ); pushAddr(32'h1000_0004, HTRANS_SEQ);
    pushAddr(32'h1000_0008, HTRANS_SEQ);    pushAddr(32'h1000_000C, HTRANS_SEQ);
    pushWords(RES_A, 4); pushDone(6, 0, 0);
    applyStimulus(32'h1000_0000, RES_A, -1, -1, -1, 3, 32'h2000_0000, -1, 0);

    $display("[TB] start during FIN");
    pushAddr(32'h1000_0040, HTRANS_NONSEQ); pushAddr(32'h1000_0044, HTRANS_SEQ);
    pushAddr(32'h1000_0048, HTRANS_SEQ);    pushAddr(32'h1000_004C, HTRANS_SEQ);
    pushWords(RES_B, 4); pushDone(6, 0, 0);
    applyStimulus(32'h1000_0042, RES_B, -1, -1, -1, 6, 32'h2000_0000, -1, 0);

    $display("[TB] reset mid-burst");
    pushAddr(32'h1000_0000, HTRANS_NONSEQ); pushAddr(32'h1000_0004, HTRANS_SEQ);
    pushAddr(32'h1000_0008, HTRANS_SEQ);    pushAddr(32'h1000_000C, HTRANS_SEQ);
    pushWords(RES_A, 4); pushDone(6, 0, 0);
    applyStimulus(32'h1000_0000, RES_A, -1, -1, -1, -1, 32'h0, 2, 0);

    $display("[TB] fresh burst after reset");
    pushAddr(32'h1000_0100, HTRANS_NONSEQ); pushAddr(32'h1000_0104, HTRANS_SEQ);
    pushAddr(32'h1000_0108, HTRANS_SEQ);    pushAddr(32'h1000_010C, HTRANS_SEQ);
    pushWords(RES_B, 4); pushDone(6, 0, 0);
    applyStimulus(32'h1000_0100, RES_B, -1, -1, -1, -1, 32'h0, -1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ndp_result_writer.md
# ndp_result_writer

AHB-Lite master that drains the NDP core's wide result vector into PS DRAM. It is the initiator counterpart of the AHB slave path that loads matrix data into the scratch pad. On a start pulse it writes the result out as consecutive 32-bit words from a base address using INCR transfers. It handles wait states and the two-cycle ERROR response, and reports completion and errors to the control register set.

## Interface
- RESULT_WIDTH, 16384: result vector width in bits; multiple of 32; N = RESULT_WIDTH/32 words.
- ADDR_WIDTH, 32: AHB address width.
- HCLK  in  1  AHB clock; single clock domain.
- HRESETn  in  1  reset; asynchronous assert, active-low.
- start  in  1  one-cycle request; ignored while busy.
- base_addr  in  ADDR_WIDTH  destination byte address; bits [1:0] are treated as 0; sampled on accepted start.
- result  in  RESULT_WIDTH  data to write; word k = result[32k+31:32k]; held stable by the source while busy.
- busy  out  1  transfer in progress.
- done  out  1  one-cycle pulse at completion, with or without error.
- error  out  1  sticky; set on ERROR response; cleared on next accepted start.
- HADDR  out  ADDR_WIDTH  address phase.
- HTRANS  out  2  IDLE 2'b00, NONSEQ 2'b10, SEQ 2'b11.
- HWRITE  out  1  constant 1 while busy, 0 otherwise.
- HSIZE  out  3  constant 3'b010 (word).
- HBURST  out  3  constant 3'b001 (INCR).
- HPROT  out  4  constant 4'b0011.
- HMASTLOCK  out  1  constant 0.
- HWDATA  out  32  data phase.
- HREADY  in  1  transfer-complete/slave-ready.
- HRESP  in  1  0 OKAY, 1 ERROR.

## Operation
- States: IDLE, XFER, DRAIN, ERR, FIN.
- IDLE: HTRANS=IDLE. start → latch base_addr, clear error, clear addr_idx and data_idx; go to XFER.
- XFER: drive HADDR = base + 4·addr_idx.
  - HTRANS is NONSEQ on the first word and on any word whose HADDR[9:0]==0 (1 KB boundary restart); otherwise SEQ.
  - On HREADY=1 the address phase is accepted: addr_idx++ and the data phase for that word is armed.
  - After word N-1 is accepted → DRAIN with HTRANS=IDLE.
- Data phase: HWDATA = word[data_idx], registered at address acceptance and held until HREADY=1. data_idx++ on each completed data phase.
- DRAIN: wait for the last data phase to complete with HREADY=1 → FIN.
- Error: HRESP=1 with HREADY=0 is the first ERROR cycle.
  - HTRANS=IDLE is driven in the following cycle, which cancels any pending address phase.
  - Set error and go to ERR; ERR waits for HREADY=1, then goes to FIN.
  - No retry.
- FIN: done=1 for one cycle, busy drops at the same edge; next state IDLE.
- Address arithmetic wraps modulo 2^ADDR_WIDTH with no checking. Index counters are $clog2(N)+1 bits.

## Timing
- Reset values: HTRANS=IDLE, HADDR=0, HWDATA=0, HWRITE=0, busy=0, done=0, error=0, state IDLE.
- Reset mid-transfer aborts immediately; no partial-burst completion.
- Start accepted at edge 0 → NONSEQ visible in cycle 1.
- With zero wait states: address phases in cycles 1..N, data phases in cycles 2..N+1, done in cycle N+2. busy is high in cycles 1..N+1.
- Each HREADY=0 cycle stretches both the current address phase and the current data phase by one cycle.
- HADDR, HTRANS and HWDATA are stable while HREADY=0, apart from the ERROR-cancel rule.
- start asserted in the FIN cycle is ignored; start is accepted from IDLE only.
- N=1: a single NONSEQ, then DRAIN.

## Structure
- Package ndp_ahb_pkg holds:
  - HTRANS_IDLE/NONSEQ/SEQ, HBURST_INCR, HSIZE_WORD, HPROT_DATA constants;
  - the state enum.
- The slave-side decoder imports the same constants.
- One sub-module, result_word_mux: selects a 32-bit word from RESULT_WIDTH by index; combinational; registered in the parent.
- Estimated RTL: about 200 lines.

## Test plan
All scenarios run with RESULT_WIDTH=128.
- Zero-wait burst:
  - Stimulus: base=0x1000_0000, result words 0x11111111..0x44444444, start.
  - Response: NONSEQ@0x1000_0000, SEQ@0x04/0x08/0x0C; HWDATA matches word order; done in cycle 6; error=0.
- Wait states:
  - Stimulus: HREADY low for 2 cycles on the second data phase.
  - Response: HADDR, HTRANS and HWDATA held; done in cycle 8; all data correct.
- 1 KB boundary:
  - Stimulus: base=0x0000_03F8.
  - Response: HTRANS NONSEQ, SEQ, NONSEQ@0x400, SEQ.
- ERROR response:
  - Stimulus: ERROR on word 1 (HRESP=1/HREADY=0, then HRESP=1/HREADY=1).
  - Response: HTRANS=IDLE in the second ERROR cycle; no further words issued; done=1, error=1.
  - Follow-up: a new start clears error.
- Start while busy:
  - Stimulus: a second start with base=0x2000_0000 in cycle 3.
  - Response: ignored; all addresses stay within 0x1000_00xx.
- Reset mid-burst:
  - Stimulus: HRESETn low in cycle 2.
  - Response: HTRANS=IDLE, busy=0, done=0 asynchronously.
  - Follow-up: after release, a fresh start completes normally.
